move_sequencer: RTL and testbench

- Sequences the PID/motor datapath for a single straight-line move of N squares.
- Accepts a move command and waits for heading error to settle with zero forward speed.
- Then ramps `frwrd` up, counts line crossings, and ramps `frwrd` down to stop.
- Drives `moving`, `frwrd`, `err_vld` and `error` into the PID block and reports busy/done to the command processor.

---
 rtl/move_sequencer.sv | 169 ++++++++++++++++
 tb/tb_move_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Straight-line move sequencer: waits for heading to settle, ramps forward speed up,
// counts line crossings, then ramps down and reports completion to the command processor.
module move_sequencer #(
    parameter logic [5:0]  FRWRD_INC  = 6'd16,
    parameter logic [9:0]  MAX_FRWRD  = 10'h2C0,
    parameter logic [11:0] SETTLE_THR = 12'd60,
    parameter logic [2:0]  SETTLE_CNT = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_go,
    input  logic [3:0]  sq_cnt,
    input  logic        stop,
    input  logic        cline,
    input  logic [11:0] hdg_err,
    input  logic        hdg_vld,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic        err_vld,
    output logic [11:0] error,
    output logic        cmd_busy,
    output logic        cmd_done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HDG_SETTLE = 3'd1,
        RAMP_UP    = 3'd2,
        RAMP_DN    = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  sq_lat;
    logic [3:0]  line_cnt;
    logic [3:0]  line_nxt;
    logic [2:0]  settle_cnt;
    logic        cline_q;
    logic        cline_rise;
    logic        settled;
    logic        settle_hit;
    logic        line_hit;

    // Sign-extend before negating so the most negative error (-2048) yields +2048.
    function automatic logic [12:0] err_mag(input logic [11:0] e);
        logic signed [12:0] s;
        s = signed'({e[11], e});
        if (s < 0)
            return $unsigned(-s);
        return $unsigned(s);
    endfunction

    // Saturating ramp-up step; the 11-bit sum cannot wrap past the 10-bit range.
    function automatic logic [9:0] step_up(input logic [9:0] f);
        logic [10:0] sum;
        sum = {1'b0, f} + {5'd0, FRWRD_INC};
        if (sum > {1'b0, MAX_FRWRD})
            return MAX_FRWRD;
        return sum[9:0];
    endfunction

    // Ramp-down uses twice the ramp-up increment and clamps at zero.
    function automatic logic [9:0] step_dn(input logic [9:0] f);
        logic [10:0] dec;
        dec = {4'd0, FRWRD_INC, 1'b0};
        if ({1'b0, f} <= dec)
            return 10'd0;
        return f - dec[9:0];
    endfunction

    assign settled    = err_mag(hdg_err) < {1'b0, SETTLE_THR};
    assign settle_hit = hdg_vld & settled & (settle_cnt == (SETTLE_CNT - 3'd1));
    assign cline_rise = cline & ~cline_q;
    assign line_nxt   = line_cnt + 4'd1;
    assign line_hit   = cline_rise & (line_nxt == sq_lat);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_go)
                    state_nxt = HDG_SETTLE;
            end
            HDG_SETTLE: begin
                if (stop)
                    state_nxt = DONE;
                else if (settle_hit)
                    state_nxt = (sq_lat == 4'd0) ? DONE : RAMP_UP;
            end
            RAMP_UP: begin
                if (stop || line_hit)
                    state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                if (frwrd == 10'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        moving   = (state != IDLE);
        cmd_busy = (state != IDLE);
        cmd_done = (state == DONE);
    end

    // Speed, counters and the PID-facing error path.
    always_ff @(posedge clk) begin
        if (rst) begin
            frwrd      <= 10'd0;
            err_vld    <= 1'b0;
            error      <= 12'd0;
            sq_lat     <= 4'd0;
            line_cnt   <= 4'd0;
            settle_cnt <= 3'd0;
            cline_q    <= 1'b0;
        end else begin
            error   <= hdg_err;
            err_vld <= hdg_vld & (state_nxt != IDLE);
            cline_q <= cline;
            case (state)
                IDLE: begin
                    frwrd <= 10'd0;
                    if (cmd_go) begin
                        sq_lat     <= sq_cnt;
                        line_cnt   <= 4'd0;
                        settle_cnt <= 3'd0;
                    end
                end
                HDG_SETTLE: begin
                    frwrd <= 10'd0;
                    if (hdg_vld)
                        settle_cnt <= settled ? (settle_cnt + 3'd1) : 3'd0;
                end
                RAMP_UP: begin
                    if (hdg_vld)
                        frwrd <= step_up(frwrd);
                    if (cline_rise)
                        line_cnt <= line_nxt;
                end
                RAMP_DN: begin
                    if (hdg_vld)
                        frwrd <= step_dn(frwrd);
                end
                DONE: begin
                    frwrd <= 10'd0;
                end
                default: begin
                    frwrd <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios plus randomized traffic checked against
// a move-level behavioural model of the sequencer.
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_go = 1'b0;
    logic [3:0]  sq_cnt = 4'd0;
    logic        stop = 1'b0;
    logic        cline = 1'b0;
    logic [11:0] hdg_err = 12'd0;
    logic        hdg_vld = 1'b0;
    logic        moving;
    logic [9:0]  frwrd;
    logic        err_vld;
    logic [11:0] error;
    logic        cmd_busy;
    logic        cmd_done;

    int total = 0;
    int bad = 0;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_UP = 2, P_DN = 3, P_DONE = 4;

    int          m_ph = P_IDLE;
    int          m_f = 0;
    int          m_lines = 0;
    int          m_settle = 0;
    int          m_sq = 0;
    bit          m_prev = 1'b0;
    bit          m_ev = 1'b0;
    logic [11:0] m_err = 12'd0;

    move_sequencer dut (
        .clk(clk), .rst(rst), .cmd_go(cmd_go), .sq_cnt(sq_cnt), .stop(stop),
        .cline(cline), .hdg_err(hdg_err), .hdg_vld(hdg_vld), .moving(moving),
        .frwrd(frwrd), .err_vld(err_vld), .error(error), .cmd_busy(cmd_busy),
        .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    // Move-level reference: what one clock edge does to the move in progress.
    task automatic model_edge();
        int  np;
        int  e;
        int  mag;
        bit  rise;
        if (rst) begin
            m_ph = P_IDLE; m_f = 0; m_lines = 0; m_settle = 0;
            m_prev = 1'b0; m_ev = 1'b0; m_err = 12'd0;
            return;
        end
        np   = m_ph;
        e    = int'($signed(hdg_err));
        mag  = (e < 0) ? -e : e;
        rise = cline && !m_prev;
        case (m_ph)
            P_IDLE: if (cmd_go) begin
                np = P_SETTLE; m_sq = int'(sq_cnt); m_lines = 0; m_settle = 0;
            end
            P_SETTLE: begin
                if (hdg_vld) m_settle = (mag < 60) ? m_settle + 1 : 0;
                if (stop) np = P_DONE;
                else if (hdg_vld && m_settle == 4) np = (m_sq == 0) ? P_DONE : P_UP;
            end
            P_UP: begin
                if (hdg_vld) m_f = (m_f + 16 > 704) ? 704 : m_f + 16;
                if (rise) m_lines++;
                if (stop || (rise && m_lines == m_sq)) np = P_DN;
            end
            P_DN: begin
                if (m_f == 0) np = P_DONE;
                if (hdg_vld) m_f = (m_f < 32) ? 0 : m_f - 32;
            end
            default: begin
                m_f = 0; np = P_IDLE;
            end
        endcase
        m_ev   = hdg_vld && (np != P_IDLE);
        m_err  = hdg_err;
        m_prev = cline;
        m_ph   = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go(input int sq);
        cmd_go = 1'b1; sq_cnt = 4'(sq);
        step();
        cmd_go = 1'b0;
    endtask

    task automatic vld(input int e);
        hdg_err = 12'(e); hdg_vld = 1'b1;
        step();
        hdg_vld = 1'b0;
    endtask

    task automatic settle_quick();
        for (int i = 0; i < 4; i++) vld(0);
    endtask

    // Drive any move in progress to completion with stop held and a strobe every cycle.
    task automatic finish_move();
        stop = 1'b1; hdg_err = 12'd0; hdg_vld = 1'b1;
        for (int i = 0; i < 200 && cmd_busy; i++) step();
        stop = 1'b0; hdg_vld = 1'b0;
        step();
        total++;
        if (cmd_busy !== 1'b0) begin
            bad++; $display("FAIL finish_timeout busy=%b required 0", cmd_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hdg_err = 12'h123; hdg_vld = 1'b1; cmd_go = 1'b1;
        step(); step();
        total++;
        if ({moving, cmd_busy, cmd_done, err_vld, frwrd, error} !== 26'd0) begin
            bad++; $display("FAIL reset_outputs got=%h required 0",
                {moving, cmd_busy, cmd_done, err_vld, frwrd, error});
        end
        rst = 1'b0; hdg_vld = 1'b0; cmd_go = 1'b0; hdg_err = 12'd0;
        step();
    endtask

    task automatic test_reset_mid_move();
        go(3);
        settle_quick();
        for (int i = 0; i < 4; i++) vld(0);
        total++;
        if (frwrd !== 10'h40) begin
            bad++; $display("FAIL midreset_pre frwrd=%h required 40", frwrd);
        end
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if ({moving, cmd_busy, cmd_done, err_vld, frwrd, error} !== 26'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h required 0",
                {moving, cmd_busy, cmd_done, err_vld, frwrd, error});
        end
        step();
        go(1);
        total++;
        if ({moving, cmd_busy} !== 2'b11) begin
            bad++; $display("FAIL midreset_restart moving/busy=%b required 11", {moving, cmd_busy});
        end
        finish_move();
    endtask

    task automatic test_settle();
        int errs [5] = '{100, 50, 40, 30, 20};
        go(2);
        for (int k = 0; k < 5; k++) begin
            vld(errs[k]);
            for (int j = 0; j < 7; j++) step();
            total++;
            if ({moving, frwrd} !== 11'h400) begin
                bad++; $display("FAIL settle_hold k=%0d moving=%b frwrd=%0d required 1/0", k, moving, frwrd);
            end
        end
        vld(0);
        total++;
        if (frwrd !== 10'd16) begin
            bad++; $display("FAIL settle_enter_ramp frwrd=%0d required 16", frwrd);
        end
        finish_move();
        go(2);
        for (int k = 0; k < 6; k++) vld(-2048);
        for (int k = 0; k < 3; k++) vld(0);
        total++;
        if ({moving, frwrd} !== 11'h400) begin
            bad++; $display("FAIL settle_neg2048 moving=%b frwrd=%0d required 1/0", moving, frwrd);
        end
        finish_move();
    endtask

    task automatic test_ramp_sat();
        int exp;
        go(5);
        settle_quick();
        for (int k = 1; k <= 50; k++) begin
            vld(0);
            exp = (16 * k > 704) ? 704 : 16 * k;
            total++;
            if (frwrd !== 10'(exp)) begin
                bad++; $display("FAIL ramp_sat k=%0d frwrd=%0d required %0d", k, frwrd, exp);
            end
        end
        finish_move();
    endtask

    task automatic test_lines();
        go(2);
        settle_quick();
        for (int k = 0; k < 44; k++) vld(0);
        cline = 1'b1; step(); cline = 1'b0; step();
        vld(0);
        total++;
        if (frwrd !== 10'd704) begin
            bad++; $display("FAIL lines_first frwrd=%0d required 704", frwrd);
        end
        cline = 1'b1;
        for (int k = 0; k < 5; k++) step();
        cline = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            vld(0);
            total++;
            if (frwrd !== 10'(704 - 32 * k)) begin
                bad++; $display("FAIL ramp_dn k=%0d frwrd=%0d required %0d", k, frwrd, 704 - 32 * k);
            end
        end
        step();
        total++;
        if ({cmd_done, moving, cmd_busy, frwrd} !== 13'h1C00) begin
            bad++; $display("FAIL done_pulse done/moving/busy=%b frwrd=%0d required 111/0",
                {cmd_done, moving, cmd_busy}, frwrd);
        end
        step();
        total++;
        if ({cmd_done, moving, cmd_busy} !== 3'b000) begin
            bad++; $display("FAIL done_idle done/moving/busy=%b required 000", {cmd_done, moving, cmd_busy});
        end
    endtask

    task automatic test_stop();
        go(3);
        settle_quick();
        for (int k = 0; k < 3; k++) vld(0);
        total++;
        if (frwrd !== 10'd48) begin
            bad++; $display("FAIL stop_pre frwrd=%0d required 48", frwrd);
        end
        stop = 1'b1; step(); stop = 1'b0;
        vld(0);
        total++;
        if (frwrd !== 10'd16) begin
            bad++; $display("FAIL stop_dn1 frwrd=%0d required 16", frwrd);
        end
        vld(0);
        total++;
        if (frwrd !== 10'd0) begin
            bad++; $display("FAIL stop_clamp frwrd=%0d required 0", frwrd);
        end
        step();
        total++;
        if (cmd_done !== 1'b1) begin
            bad++; $display("FAIL stop_done cmd_done=%b required 1", cmd_done);
        end
        step();
        total++;
        if (cmd_busy !== 1'b0) begin
            bad++; $display("FAIL stop_idle busy=%b required 0", cmd_busy);
        end
    endtask

    task automatic test_sq0();
        go(0);
        for (int k = 0; k < 4; k++) begin
            vld(0);
            total++;
            if (frwrd !== 10'd0) begin
                bad++; $display("FAIL sq0_frwrd k=%0d frwrd=%0d required 0", k, frwrd);
            end
        end
        total++;
        if (cmd_done !== 1'b1) begin
            bad++; $display("FAIL sq0_done cmd_done=%b required 1", cmd_done);
        end
        step();
        total++;
        if (cmd_busy !== 1'b0) begin
            bad++; $display("FAIL sq0_idle busy=%b required 0", cmd_busy);
        end
    endtask

    task automatic test_cmd_ignored();
        go(1);
        settle_quick();
        for (int k = 0; k < 3; k++) vld(0);
        go(3);
        total++;
        if ({cmd_busy, frwrd} !== {1'b1, 10'd48}) begin
            bad++; $display("FAIL ignore_go busy=%b frwrd=%0d required 1/48", cmd_busy, frwrd);
        end
        cline = 1'b1; step(); cline = 1'b0; step();
        vld(0);
        total++;
        if (frwrd !== 10'd16) begin
            bad++; $display("FAIL ignore_sq frwrd=%0d required 16", frwrd);
        end
        finish_move();
    endtask

    task automatic test_errvld();
        vld(12'h5A5);
        total++;
        if ({err_vld, error} !== {1'b0, 12'h5A5}) begin
            bad++; $display("FAIL errvld_idle err_vld=%b error=%h required 0/5a5", err_vld, error);
        end
        go(1);
        vld(12'hF00);
        total++;
        if ({err_vld, error} !== {1'b1, 12'hF00}) begin
            bad++; $display("FAIL errvld_settle err_vld=%b error=%h required 1/f00", err_vld, error);
        end
        step();
        total++;
        if (err_vld !== 1'b0) begin
            bad++; $display("FAIL errvld_width err_vld=%b required 0", err_vld);
        end
        finish_move();
    endtask

    task automatic test_random();
        logic [25:0] exp;
        int          e;
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            cmd_go  = ($urandom_range(0, 19) == 0);
            sq_cnt  = 4'($urandom_range(0, 3));
            stop    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) cline = ~cline;
            hdg_vld = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                            : int'($urandom_range(0, 140)) - 70;
            hdg_err = 12'(e);
            step();
            exp = {m_ph != P_IDLE, m_ph != P_IDLE, m_ph == P_DONE, m_ev, 10'(m_f), m_err};
            total++;
            if ({moving, cmd_busy, cmd_done, err_vld, frwrd, error} !== exp) begin
                bad++; $display("FAIL random c=%0d got=%h required %h", c,
                    {moving, cmd_busy, cmd_done, err_vld, frwrd, error}, exp);
            end
        end
        rst = 1'b0; cmd_go = 1'b0; stop = 1'b0; cline = 1'b0; hdg_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_errvld();
        test_reset_mid_move();
        test_settle();
        test_ramp_sat();
        test_lines();
        test_stop();
        test_sq0();
        test_cmd_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
